// File: rtl/pb_key_sequencer.sv
// pb_key_sequencer
// Front end between the push buttons and the calculator datapath. Each button
// is synchronized and debounced. Each accepted press becomes a key code that is
// queued in a small FIFO. The consumer drains the FIFO through valid/ready.
//
// Ports:
//   clk          system clock
//   nrst         asynchronous active-low reset
//   ncs          chip select, active low; high flushes the queue and drops presses
//   pb           raw asynchronous button levels, active high
//   key_code     button index at the FIFO head (0 when key_valid is low)
//   key_valid    FIFO not empty and ncs low
//   key_ready    consumer accepts the head when key_valid & key_ready
//   overflow     sticky flag: a press was lost
//   clr_overflow synchronous clear of overflow
module pb_key_sequencer #(
    parameter int NUM_PB          = 10,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ncs,
    input  logic [NUM_PB-1:0] pb,
    output logic [3:0]        key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    // Counter value at which one more unstable cycle completes the debounce window
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_PB-1:0]         sync1_q, sync2_q;
    logic [NUM_PB-1:0]         stable_q, stable_d, stable_prev_q;
    logic [NUM_PB-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_PB-1:0]         pending_q, pending_d;
    logic [NUM_PB-1:0]         press, clr_mask;
    logic [3:0]                push_code;
    logic                      push_found;
    logic                      push, pop, full, empty;
    logic                      ovf_set;
    logic                      overflow_q;
    logic [AW:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]                mem_q [FIFO_DEPTH];

    // Debounce: stable toggles only after DEBOUNCE_CYCLES consecutive differing cycles
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_PB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;

    // Lowest-index pending button wins the single push slot
    always_comb begin
        push_code  = '0;
        push_found = 1'b0;
        clr_mask   = '0;
        for (int i = 0; i < NUM_PB; i++) begin
            if (pending_q[i] && !push_found) begin
                push_found  = 1'b1;
                push_code   = 4'(i);
                clr_mask[i] = 1'b1;
            end
        end
    end

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign key_valid = ~empty & ~ncs;
    assign key_code  = key_valid ? mem_q[rd_ptr_q[AW-1:0]] : 4'd0;
    assign overflow  = overflow_q;
    assign pop       = key_valid & key_ready;
    assign push      = push_found & ~ncs & (~full | pop);

    // A press on a bit that is being pushed this cycle is not lost, so no overflow
    assign ovf_set = ~ncs & (|(press & pending_q & ~(push ? clr_mask : '0)));

    always_comb begin
        if (ncs) begin
            pending_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end else begin
            // Set after clear: a new press on the pushed bit survives
            pending_d = (pending_q & ~(push ? clr_mask : '0)) | press;
            wr_ptr_d  = push ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
            rd_ptr_d  = pop ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            cnt_q         <= '0;
            pending_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            overflow_q    <= 1'b0;
        end else begin
            sync1_q       <= pb;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Storage needs no reset: key_code is gated by key_valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_code;
        end
    end

endmodule

// File: tb/tb_pb_key_sequencer.sv
module tb_pb_key_sequencer;

    localparam int NUM_PB = 10;
    localparam int DB     = 4;
    localparam int FD     = 4;

    logic              clk = 1'b0;
    logic              nrst;
    logic              ncs;
    logic [NUM_PB-1:0] pb;
    logic [3:0]        key_code;
    logic              key_valid;
    logic              key_ready;
    logic              overflow;
    logic              clr_overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int valid_seen;
    int got[$];
    int got_cyc[$];

    pb_key_sequencer #(
        .NUM_PB         (NUM_PB),
        .DEBOUNCE_CYCLES(DB),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .ncs         (ncs),
        .pb          (pb),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample the current cycle (handshake happens at the coming edge), then advance
    task automatic run(input int n);
        repeat (n) begin
            if (key_valid) valid_seen++;
            if (key_valid && key_ready) begin
                got.push_back(int'(key_code));
                got_cyc.push_back(cyc);
            end
            step();
        end
    endtask

    task automatic clear_log();
        got.delete();
        got_cyc.delete();
        valid_seen = 0;
    endtask

    function automatic int at(input int i);
        return (i < got.size()) ? got[i] : -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int early;
        int d;
        nrst         = 1'b0;
        ncs          = 1'b0;
        pb           = '0;
        key_ready    = 1'b0;
        clr_overflow = 1'b0;
        clear_log();
        step();
        step();
        chk("reset_valid", key_valid, 0);
        chk("reset_code", key_code, 0);
        chk("reset_overflow", overflow, 0);
        nrst = 1'b1;
        step();

        // Single press: valid exactly after edge 8, one code, release is silent
        key_ready = 1'b1;
        pb[3]     = 1'b1;
        early     = 0;
        for (int n = 1; n <= 7; n++) begin
            step();
            if (key_valid) early++;
        end
        chk("t1_no_early_valid", early, 0);
        step();
        chk("t1_valid_at_8", key_valid, 1);
        chk("t1_code", key_code, 3);
        step();
        chk("t1_single_cycle", key_valid, 0);
        run(3);
        pb[3] = 1'b0;
        clear_log();
        run(12);
        chk("t1_release_quiet", valid_seen, 0);

        // Bounce rejection
        clear_log();
        pb[5] = 1'b1; run(3);
        pb[5] = 1'b0; run(1);
        pb[5] = 1'b1; run(2);
        pb[5] = 1'b0; run(10);
        chk("t2_bounce_no_valid", valid_seen, 0);
        chk("t2_bounce_no_ovf", overflow, 0);
        clear_log();
        pb[5] = 1'b1; run(8);
        pb[5] = 1'b0; run(10);
        chk("t2_hold_count", got.size(), 1);
        chk("t2_hold_code", at(0), 5);

        // Simultaneous press serialized lowest index first
        clear_log();
        pb[2] = 1'b1;
        pb[7] = 1'b1;
        run(12);
        pb = '0;
        run(10);
        chk("t3_count", got.size(), 2);
        chk("t3_first", at(0), 2);
        chk("t3_second", at(1), 7);
        d = (got_cyc.size() == 2) ? got_cyc[1] - got_cyc[0] : -1;
        chk("t3_back_to_back", d, 1);

        // Full FIFO backpressure and overflow
        key_ready = 1'b0;
        for (int b = 0; b < 5; b++) begin
            pb[b] = 1'b1; run(8);
            pb[b] = 1'b0; run(8);
        end
        chk("t4_full_valid", key_valid, 1);
        chk("t4_full_head", key_code, 0);
        chk("t4_no_ovf_yet", overflow, 0);
        pb[4] = 1'b1; run(8);
        pb[4] = 1'b0; run(8);
        chk("t4_ovf_set", overflow, 1);
        clear_log();
        key_ready = 1'b1;
        run(10);
        chk("t4_drain_count", got.size(), 5);
        for (int i = 0; i < 5; i++) chk("t4_drain_order", at(i), i);
        chk("t4_ovf_sticky", overflow, 1);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("t4_ovf_cleared", overflow, 0);

        // ncs flushes the queue and drops presses
        key_ready = 1'b0;
        pb[8] = 1'b1;
        pb[9] = 1'b1;
        run(10);
        pb = '0;
        run(8);
        chk("t5_queued_valid", key_valid, 1);
        chk("t5_queued_head", key_code, 8);
        ncs = 1'b1;
        step();
        chk("t5_ncs_valid_low", key_valid, 0);
        pb[6] = 1'b1; run(8);
        pb[6] = 1'b0; run(8);
        ncs = 1'b0;
        clear_log();
        run(6);
        chk("t5_flushed", valid_seen, 0);
        chk("t5_ncs_no_ovf", overflow, 0);

        // Reset mid-debounce with a code queued
        pb[0] = 1'b1; run(10);
        pb[0] = 1'b0;
        pb[1] = 1'b1; run(4);
        chk("t6_pre_reset_valid", key_valid, 1);
        nrst  = 1'b0;
        pb[1] = 1'b0;
        #1;
        chk("t6_rst_valid", key_valid, 0);
        chk("t6_rst_code", key_code, 0);
        chk("t6_rst_ovf", overflow, 0);
        step();
        step();
        nrst      = 1'b1;
        key_ready = 1'b1;
        clear_log();
        run(12);
        chk("t6_no_code_after_rst", got.size(), 0);
        pb[1] = 1'b1; run(10);
        pb[1] = 1'b0; run(8);
        chk("t6_repress_count", got.size(), 1);
        chk("t6_repress_code", at(0), 1);
        chk("t6_final_ovf", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
